// File: rtl/cordic_demod_pkg.sv
// Shared constants and types for the CORDIC post-processing demodulator.
package cordic_demod_pkg;

   // Phase wrap limits, in degrees.
   localparam int DEG_180 = 180;
   localparam int DEG_360 = 360;

   // CORDIC gain correction: r * (2^-1 + 2^-3 - 2^-6) ~= r * 0.609 ~= r / 1.63.
   localparam int unsigned GAIN_SH_1 = 1;
   localparam int unsigned GAIN_SH_3 = 3;
   localparam int unsigned GAIN_SH_6 = 6;  // subtracted term

   // Default sample types shared with the CORDIC vectoring stage.
   typedef logic signed [8:0] phase_t;
   typedef logic signed [7:0] data_t;

endpackage

// File: rtl/mov_avg.sv
// 2^L-sample moving average: window shift register, running sum, divide by 2^L.
module mov_avg #(
   parameter int unsigned W = 7,
   parameter int unsigned L = 3
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                en_i,
   input  logic signed [W:0]   din_i,
   output logic signed [W:0]   dout_o
);

   localparam int unsigned N    = 1 << L;
   localparam int unsigned AccW = W + 1 + L;

   logic signed [W:0]      win_q [N];
   logic signed [AccW-1:0] acc_q;
   logic signed [AccW-1:0] acc_d;

   // Running sum: add the newest sample, drop the one leaving the window.
   always_comb begin
      acc_d = acc_q + AccW'(din_i) - AccW'(win_q[N-1]);
   end

   // Window and accumulator advance only on accepted samples.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         acc_q <= '0;
         for (int i = 0; i < N; i++) begin
            win_q[i] <= '0;
         end
      end else if (en_i) begin
         acc_q    <= acc_d;
         win_q[0] <= din_i;
         for (int i = 1; i < N; i++) begin
            win_q[i] <= win_q[i-1];
         end
      end
   end

   // Sum never exceeds 2^L full-scale samples, so the quotient fits in W+1 bits.
   always_comb begin
      dout_o = (W+1)'(acc_q >>> L);
   end

endmodule

// File: rtl/cordic_demod.sv
// FM / AM / carrier-level demodulator fed by the CORDIC radius and phase stream.
// Two register stages: raw phase difference + gain correction, then wrap + outputs.
module cordic_demod
   import cordic_demod_pkg::*;
#(
   parameter int unsigned W = $bits(data_t) - 1,
   parameter int unsigned P = $bits(phase_t) - 1,
   parameter int unsigned L = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   input  logic signed [W:0] r_i,
   input  logic signed [P:0] phi_i,
   output logic              out_valid_o,
   output logic signed [P:0] freq_o,
   output logic signed [W:0] mag_o,
   output logic signed [W:0] avg_o
);

   localparam logic signed [P+1:0] D180 = (P+2)'(DEG_180);
   localparam logic signed [P+1:0] D360 = (P+2)'(DEG_360);

   logic signed [P+1:0] d_d, d_s1_q, d_wrap;
   logic signed [W:0]   mag_d, mag_s1_q, avg_d;
   logic signed [P:0]   phi_prev_q;
   logic                primed_q, valid_s1_q;
   logic signed [P:0]   freq_q;
   logic signed [W:0]   mag_q, avg_q;
   logic                out_valid_q;

   // Gain correction and raw phase difference; first sample after reset has no history.
   always_comb begin
      mag_d = (r_i >>> GAIN_SH_1) + (r_i >>> GAIN_SH_3) - (r_i >>> GAIN_SH_6);
      d_d   = primed_q ? ((P+2)'(phi_i) - (P+2)'(phi_prev_q)) : '0;
   end

   // Stage 1: capture difference and magnitude, remember phase for the next sample.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_s1_q <= 1'b0;
         d_s1_q     <= '0;
         mag_s1_q   <= '0;
         phi_prev_q <= '0;
         primed_q   <= 1'b0;
      end else begin
         valid_s1_q <= in_valid_i;
         if (in_valid_i) begin
            d_s1_q     <= d_d;
            mag_s1_q   <= mag_d;
            phi_prev_q <= phi_i;
            primed_q   <= 1'b1;
         end
      end
   end

   mov_avg #(
      .W (W),
      .L (L)
   ) u_mov_avg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (in_valid_i),
      .din_i   (mag_d),
      .dout_o  (avg_d)
   );

   // Fold the difference into [-180, 179]; one correction suffices for legal phases.
   always_comb begin
      d_wrap = d_s1_q;
      if (d_s1_q >= D180) begin
         d_wrap = d_s1_q - D360;
      end else if (d_s1_q < -D180) begin
         d_wrap = d_s1_q + D360;
      end
   end

   // Stage 2: registered outputs, held across bubbles.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         out_valid_q <= 1'b0;
         freq_q      <= '0;
         mag_q       <= '0;
         avg_q       <= '0;
      end else begin
         out_valid_q <= valid_s1_q;
         if (valid_s1_q) begin
            freq_q <= (P+1)'(d_wrap);
            mag_q  <= mag_s1_q;
            avg_q  <= avg_d;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign freq_o      = freq_q;
   assign mag_o       = mag_q;
   assign avg_o       = avg_q;

endmodule

// File: tb/tb_cordic_demod.sv
// Self-checking bench for cordic_demod: directed cases plus randomized traffic
// compared against a sample-level reference model.
module tb_cordic_demod;

   localparam int W = 7;
   localparam int P = 8;
   localparam int L = 3;
   localparam int N = 1 << L;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic signed [W:0] r_in;
   logic signed [P:0] phi_in;
   logic              out_valid;
   logic signed [P:0] freq;
   logic signed [W:0] mag;
   logic signed [W:0] avg;

   cordic_demod #(
      .W (W),
      .P (P),
      .L (L)
   ) dut (
      .clk_i       (clk),
      .reset_i     (rst),
      .in_valid_i  (in_valid),
      .r_i         (r_in),
      .phi_i       (phi_in),
      .out_valid_o (out_valid),
      .freq_o      (freq),
      .mag_o       (mag),
      .avg_o       (avg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int f;
      int m;
      int a;
   } exp_t;

   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   int   m_prev_phi;
   bit   m_primed;
   int   m_win[$];
   exp_t m_held;
   exp_t pend;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Floor division, the arithmetic meaning of a right shift.
   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
      return q;
   endfunction

   task automatic model_reset();
      m_primed   = 1'b0;
      m_prev_phi = 0;
      m_win.delete();
      for (int i = 0; i < N; i++) m_win.push_back(0);
      m_held = '{v: 1'b0, f: 0, m: 0, a: 0};
      pend   = m_held;
   endtask

   task automatic model_sample(input bit v, input int r, input int phi, output exp_t e);
      int d, m, sum;
      if (v) begin
         d = m_primed ? phi - m_prev_phi : 0;
         if (d >= 180) d -= 360;
         else if (d < -180) d += 360;
         m = fdiv(r * 39, 64);  // 0.609375 * r, truncated toward -inf per term below
         m = fdiv(r, 2) + fdiv(r, 8) - fdiv(r, 64);
         m_win.push_front(m);
         void'(m_win.pop_back());
         sum = 0;
         foreach (m_win[i]) sum += m_win[i];
         m_held     = '{v: 1'b1, f: d, m: m, a: fdiv(sum, N)};
         m_prev_phi = phi;
         m_primed   = 1'b1;
      end
      e   = m_held;
      e.v = v;
   endtask

   task automatic check_outputs(input exp_t e);
      check_val("out_valid", int'(out_valid), int'(e.v));
      check_val("freq", int'(freq), e.f);
      check_val("mag", int'(mag), e.m);
      check_val("avg", int'(avg), e.a);
   endtask

   // One clock: drive at negedge, model at posedge, check the previous edge's sample.
   task automatic step(input bit v, input int r, input int phi);
      exp_t nx;
      @(negedge clk);
      in_valid = v;
      r_in     = 8'(r);
      phi_in   = 9'(phi);
      @(posedge clk);
      model_sample(v, r, phi, nx);
      #1;
      check_outputs(pend);
      pend = nx;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_freq", int'(freq), 0);
      check_val("rst_mag", int'(mag), 0);
      check_val("rst_avg", int'(avg), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int avg_tab[10];
      int pa[4];
      int pb[4];
      int pf[4];
      int duty;
      bit v;

      avg_tab = '{7, 15, 22, 30, 38, 45, 53, 61, 61, 61};
      pa      = '{170, -170, 0, 90};
      pb      = '{-170, 170, 180, -90};
      pf      = '{20, -20, -180, -180};

      rst      = 1'b0;
      in_valid = 1'b0;
      r_in     = '0;
      phi_in   = '0;
      model_reset();

      // Constant phase: freq stays 0, first valid two cycles after first input
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 50, 10);
         if (i == 0) check_val("lat_not_yet", int'(out_valid), 0);
         else check_val("const_freq", int'(freq), 0);
      end

      // Constant radius: gain correction and average ramp
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 100, 0);
         if (i >= 1) begin
            check_val("mag_100", int'(mag), 61);
            check_val("avg_ramp", int'(avg), avg_tab[i-1]);
         end
      end
      step(1'b0, 0, 0);
      check_val("avg_ramp_last", int'(avg), avg_tab[9]);

      do_reset();
      step(1'b1, 127, 0);
      step(1'b0, 0, 0);
      check_val("mag_127", int'(mag), 77);

      // Phase wrap pairs
      for (int k = 0; k < 4; k++) begin
         do_reset();
         step(1'b1, 100, pa[k]);
         step(1'b1, 100, pb[k]);
         check_val("pair_first", int'(freq), 0);
         step(1'b0, 0, 0);
         check_val("pair_wrap", int'(freq), pf[k]);
      end

      // Bubbles propagate; accumulator untouched during the gap
      do_reset();
      step(1'b1, 100, 30);
      step(1'b0, 0, 0);
      check_val("gap_v1", int'(out_valid), 1);
      step(1'b0, 0, 0);
      check_val("gap_v0a", int'(out_valid), 0);
      step(1'b1, 100, 40);
      check_val("gap_v0b", int'(out_valid), 0);
      step(1'b0, 0, 0);
      check_val("gap_v2", int'(out_valid), 1);
      check_val("gap_freq", int'(freq), 10);
      check_val("gap_avg", int'(avg), 15);

      // Reset mid-stream discards history
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 100, i * 10);
      do_reset();
      step(1'b1, 100, 50);
      step(1'b0, 0, 0);
      check_val("post_rst_freq", int'(freq), 0);
      check_val("post_rst_avg", int'(avg), 7);

      // Randomized traffic with varying duty cycle
      do_reset();
      duty = 100;
      for (int i = 0; i < 10000; i++) begin
         if (i % 100 == 0) duty = int'($urandom_range(10, 100));
         v = (int'($urandom_range(1, 100)) <= duty);
         step(v, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 360)) - 180);
      end
      step(1'b0, 0, 0);
      step(1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cordic_demod.md
# cordic_demod

Post-processing stage placed directly after the 3-iteration CORDIC vectoring pipeline. It consumes the CORDIC radius and phase-in-degrees stream and produces three outputs: an instantaneous frequency (FM discriminator output), a gain-corrected magnitude (AM output), and a 2^L-sample moving-average magnitude (carrier-level estimate). The block is fully pipelined, accepts one sample per clock under a valid strobe, and has a fixed latency of 2 cycles.

## Interface
- W, 7: data bit width − 1 for r, mag, avg.
- P, 8: phase bit width − 1 for phi, freq. Must satisfy P ≥ 8 so that ±180 is representable.
- L, 3: log2 of the moving-average window length (window = 2^L samples, L ≥ 1).

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  r/phi sample valid this cycle.
- r  in  signed [W:0]  CORDIC radius, carries CORDIC gain ≈1.63.
- phi  in  signed [P:0]  phase in degrees, legal range [−180, 180].
- out_valid  out  1  freq/mag/avg valid this cycle.
- freq  out  signed [P:0]  phase difference in degrees per sample, range [−180, 179].
- mag  out  signed [W:0]  gain-corrected radius.
- avg  out  signed [W:0]  moving average of mag.

## Operation
- State held across samples:
  - phi_prev: last accepted phase.
  - primed: at least one sample accepted since reset.
  - window: 2^L-entry shift register of mag values.
  - acc: running sum, width W+1+L.
- On every in_valid sample:
  - d = phi − phi_prev, computed in P+2 bits.
  - If primed = 0: d is forced to 0.
  - Wrap: if d ≥ 180, d −= 360; if d < −180, d += 360. freq = d truncated to P+1 bits (always in range after the wrap).
  - phi_prev ← phi; primed ← 1.
  - mag = (r>>>1) + (r>>>3) − (r>>>6), arithmetic shifts, computed at W+1 bits. This approximates 1/1.63 (×0.609).
  - acc ← acc + mag − window[oldest]; shift mag into window.
  - avg = acc>>>L.
- Window is zero-filled at reset, so avg ramps up over the first 2^L samples.
- Cycles with in_valid = 0:
  - No state changes.
  - The pipeline bubble propagates, so out_valid is 0 two cycles later.
- Phi outside [−180, 180]: freq is unspecified; the block must not lock up, and subsequent legal samples must produce correct output.
- Negative r is processed arithmetically; no clamping.

## Timing
- Latency: sample presented with in_valid at edge n → outputs with out_valid = 1 after edge n+2.
- Stage 1 registers:
  - raw d (P+2 bits), primed-masked;
  - mag;
  - updated acc;
  - valid.
- Stage 2 registers: wrapped freq, mag, avg = acc>>>L, out_valid.
- Throughput: 1 sample per clock; back-to-back valid samples are supported.
- Outputs hold their last values while out_valid = 0.
- Reset values (asynchronous): out_valid, freq, mag, avg, acc, all window entries, phi_prev, primed, and the stage-1 registers are all 0.
- Reset asserted mid-stream:
  - In-flight samples are discarded.
  - The first sample after reset yields freq = 0 and avg = mag>>>L.

## Structure
- Shared package:
  - DEG_180 = 180 and DEG_360 = 360 constants;
  - CORDIC gain-correction shift set (1, 3, −6);
  - phase and data width typedefs shared with the CORDIC stage.
- One sub-module, `mov_avg`: window shift register, acc, and divide-by-2^L, with ports clk, reset, en, din, dout. The phase path stays in the top level.

## Test plan
- Reset, then phi = 10 on every sample with in_valid continuously high → first out_valid 2 cycles after first in_valid; freq = 0 on all outputs.
- Phi sequence 170, −170 → freq 0, +20. Sequence −170, 170 → freq 0, −20. Sequence 0, 180 → freq 0, −180. Sequence 90, −90 → freq 0, −180.
- r = 100 constant for 10 samples → mag = 61 on every output; avg = 7, 15, 22, 30, 38, 45, 53, 61, 61, 61. Also r = 127 → mag = 77.
- in_valid pattern 1,0,0,1 with phi 30, 40 → out_valid pattern 1,0,0,1 delayed by 2 cycles; freq 0, 10; acc unchanged during the gap.
- Assert reset mid-stream after 5 samples at r = 100 → all outputs 0 immediately. Then phi = 50, r = 100 → freq = 0, avg = 7.
- Random phi in [−180, 180] and r for 10k samples → compare against a reference model, including wrap cases and a randomised in_valid duty cycle.
